if_fetch_unit: RTL and testbench

Instruction-fetch stage of the 16-bit pipelined MIPS: owns the PC, issues requests to a variable-latency instruction memory, and is the producer side of the IF/ID pipeline register. It drives `instruction` and `pc_plus_2` into IF/ID and obeys the stall (IF/ID enable) and branch/jump redirect from the later stages. When no valid instruction is available, it presents a NOP.

---
 rtl/pipeline_defs.sv | 33 +++
 rtl/if_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_defs.sv
`default_nettype none
// ============================================================================
// Package     : pipeline_defs
// Description : Shared definitions for the 16-bit pipelined MIPS front end.
//               Holds the instruction width, the NOP encoding, the fetch FSM
//               state encodings and a small PC-increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_defs;

   localparam int INSTR_W = 16;

   // Encoding presented to IF/ID whenever no real instruction is buffered.
   localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

   // Fetch FSM state encodings.
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DROP = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_WAIT = WAIT,
      ST_DROP = DROP
   } fetch_state_e;

   // Next sequential instruction address. 16-bit wrap-around, carry discarded.
   function automatic logic [15:0] pc_add2(input logic [15:0] a);
      return a + 16'd2;
   endfunction

endpackage : pipeline_defs
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch stage. Owns the PC, issues requests to a
//               variable-latency instruction memory and feeds the IF/ID
//               register through a one-entry output buffer. Honours the
//               hazard-unit stall and branch/jump redirects; presents a NOP
//               whenever no real instruction is buffered.
// Ports       :
//   clk             - clock, all state changes on the rising edge
//   rst             - synchronous active-high reset
//   stall           - hazard hold (IF/ID enable is ~stall)
//   redirect        - taken branch/jump from a later stage
//   redirect_target - new PC (bit 0 ignored)
//   imem_req        - memory request valid
//   imem_addr       - memory request address, stable while imem_req is high
//   imem_ready      - memory response strobe
//   imem_rdata      - memory instruction word
//   instruction     - instruction to IF/ID (NOP when nothing buffered)
//   pc_plus_2       - address of the buffered instruction + 2
//   if_valid        - a real instruction is presented
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit
   import pipeline_defs::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                redirect,
   input  logic [15:0]         redirect_target,
   output logic                imem_req,
   output logic [15:0]         imem_addr,
   input  logic                imem_ready,
   input  logic [INSTR_W-1:0]  imem_rdata,
   output logic [INSTR_W-1:0]  instruction,
   output logic [15:0]         pc_plus_2,
   output logic                if_valid
);

   fetch_state_e        state_q, state_d;
   logic [15:0]         pc_q, pc_d;
   logic [15:0]         addr_q, addr_d;
   logic [INSTR_W-1:0]  buf_instr_q, buf_instr_d;
   logic [15:0]         buf_pc2_q, buf_pc2_d;
   logic                buf_valid_q, buf_valid_d;
   logic                req_q, req_d;

   logic                consume;
   logic                buf_free;
   logic [15:0]         target;
   logic                target_lsb_unused;

   // Instructions are halfword aligned; the LSB of a redirect is dropped.
   assign target            = {redirect_target[15:1], 1'b0};
   assign target_lsb_unused = redirect_target[0];

   // IF/ID latched the buffered instruction on the preceding falling edge.
   assign consume  = buf_valid_q & ~stall;
   assign buf_free = ~buf_valid_q | consume;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      addr_d      = addr_q;
      buf_instr_d = buf_instr_q;
      buf_pc2_d   = buf_pc2_q;
      buf_valid_d = buf_valid_q;

      // A consumed entry empties the buffer unless reloaded below.
      if (consume) begin
         buf_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (redirect) begin
               pc_d        = target;
               buf_valid_d = 1'b0;
            end else if (buf_free) begin
               addr_d  = pc_q;
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (imem_ready) begin
               if (redirect) begin
                  // Response belongs to the abandoned path.
                  pc_d        = target;
                  buf_valid_d = 1'b0;
               end else begin
                  buf_instr_d = imem_rdata;
                  buf_pc2_d   = pc_add2(addr_q);
                  buf_valid_d = 1'b1;
                  pc_d        = pc_add2(addr_q);
               end
               state_d = ST_IDLE;
            end else if (redirect) begin
               // The request cannot be withdrawn; wait out its response.
               pc_d        = target;
               buf_valid_d = 1'b0;
               state_d     = ST_DROP;
            end
         end

         ST_DROP: begin
            if (redirect) begin
               pc_d        = target;
               buf_valid_d = 1'b0;
            end
            if (imem_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Request flag is registered from the next state so imem_req is a flop.
      req_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_PC;
         addr_q      <= RESET_PC;
         buf_instr_q <= NOP_INSTR;
         buf_pc2_q   <= 16'h0000;
         buf_valid_q <= 1'b0;
         req_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         addr_q      <= addr_d;
         buf_instr_q <= buf_instr_d;
         buf_pc2_q   <= buf_pc2_d;
         buf_valid_q <= buf_valid_d;
         req_q       <= req_d;
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   assign instruction = buf_valid_q ? buf_instr_q : NOP_INSTR;
   assign pc_plus_2   = buf_pc2_q;
   assign if_valid    = buf_valid_q;

endmodule : if_fetch_unit
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Self-checking bench for if_fetch_unit. A behavioural memory
//               answers requests after a programmable latency; expected
//               request addresses and IF/ID outputs are queued by the test and
//               checked on the falling edge when the DUT issues/presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

   typedef struct {
      int          lat;
      logic [15:0] addr;
      logic [15:0] exp_instr;
      logic [15:0] exp_pc2;
   } vec_t;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] pc2;
   } out_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_target = 16'h0000;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [15:0] imem_rdata = 16'hBAD0;
   logic [15:0] instruction;
   logic [15:0] pc_plus_2;
   logic        if_valid;

   int n_cmp = 0;
   int n_fail = 0;
   int n_pop = 0;
   int lat = 1;
   int cur_lat = 1;
   int mcnt = 0;

   logic [15:0] addr_exp[$];
   out_t        out_exp[$];
   logic        req_prev = 1'b0;
   logic        prev_consume = 1'b0;
   out_t        mon_e;

   if_fetch_unit #(.RESET_PC(16'h0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .imem_rdata      (imem_rdata),
      .instruction     (instruction),
      .pc_plus_2       (pc_plus_2),
      .if_valid        (if_valid)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'hC3A5;
   endfunction

   task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_out(input logic [15:0] a, input logic [15:0] pc2);
      out_t e;
      e.instr = mem_word(a);
      e.pc2   = pc2;
      out_exp.push_back(e);
   endtask

   // Memory: answers after cur_lat falling edges of a continuous request.
   initial forever begin
      @(negedge clk);
      if (!imem_req || imem_ready) begin
         imem_ready = 1'b0;
         imem_rdata = 16'hBAD0;
         mcnt       = 0;
      end else begin
         if (mcnt == 0) cur_lat = lat;
         mcnt++;
         if (mcnt >= cur_lat) begin
            imem_ready = 1'b1;
            imem_rdata = mem_word(imem_addr);
         end
      end
   end

   // Scoreboard monitor: sampled on the edge IF/ID uses.
   always @(negedge clk) begin
      if (imem_req && !req_prev) begin
         if (addr_exp.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_request: got addr %h expected none", imem_addr);
         end else begin
            check16("req_addr", imem_addr, addr_exp.pop_front());
         end
      end
      req_prev = imem_req;
      if (prev_consume) check1("bubble_after_consume", if_valid, 1'b0);
      if (if_valid && !stall) begin
         if (out_exp.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_instr: got %h expected none", instruction);
         end else begin
            mon_e = out_exp.pop_front();
            check16("instruction", instruction, mon_e.instr);
            check16("pc_plus_2", pc_plus_2, mon_e.pc2);
         end
         n_pop++;
      end
      prev_consume = if_valid && !stall;
   end

   task automatic wait_pops(input int target);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (n_pop >= target) return;
      end
      n_cmp++; n_fail++;
      $display("FAIL wait_pops_timeout: got %0d pops expected %0d", n_pop, target);
   endtask

   task automatic wait_valid_and_stall(input string name);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (if_valid) begin
            stall = 1'b1;
            return;
         end
      end
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: got if_valid 0 expected 1", name);
   endtask

   vec_t rows[6];
   out_t e;

   initial begin
      rows[0] = '{1, 16'h0000, mem_word(16'h0000), 16'h0002};
      rows[1] = '{1, 16'h0002, mem_word(16'h0002), 16'h0004};
      rows[2] = '{1, 16'h0004, mem_word(16'h0004), 16'h0006};
      rows[3] = '{3, 16'h0006, mem_word(16'h0006), 16'h0008};
      rows[4] = '{2, 16'h0008, mem_word(16'h0008), 16'h000A};
      rows[5] = '{1, 16'h000A, mem_word(16'h000A), 16'h000C};

      // Reset state
      lat = rows[0].lat;
      addr_exp.push_back(rows[0].addr);
      e.instr = rows[0].exp_instr; e.pc2 = rows[0].exp_pc2;
      out_exp.push_back(e);
      repeat (3) @(posedge clk);
      #1;
      check1 ("rst_imem_req", imem_req, 1'b0);
      check16("rst_imem_addr", imem_addr, 16'h0000);
      check16("rst_instruction", instruction, 16'h0000);
      check16("rst_pc_plus_2", pc_plus_2, 16'h0000);
      check1 ("rst_if_valid", if_valid, 1'b0);
      rst = 1'b0;

      // Straight-line fetch, varying memory latency
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin
            lat = rows[i].lat;
            addr_exp.push_back(rows[i].addr);
            e.instr = rows[i].exp_instr; e.pc2 = rows[i].exp_pc2;
            out_exp.push_back(e);
         end
         wait_pops(i + 1);
      end

      // Stall for 5 cycles with a buffered instruction
      addr_exp.push_back(16'h000C);
      push_out(16'h000C, 16'h000E);
      wait_valid_and_stall("stall_fill");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check16("stall_instruction", instruction, mem_word(16'h000C));
         check16("stall_pc_plus_2", pc_plus_2, 16'h000E);
         check1 ("stall_imem_req", imem_req, 1'b0);
      end
      addr_exp.push_back(16'h000E);
      push_out(16'h000E, 16'h0010);
      stall = 1'b0;
      wait_valid_and_stall("resume");

      // Redirect while waiting on a slow response
      lat = 4;
      addr_exp.push_back(16'h0010);
      stall = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      redirect = 1'b1; redirect_target = 16'h0041;
      @(posedge clk); #1;
      redirect = 1'b0;
      check1 ("drop_if_valid", if_valid, 1'b0);
      check1 ("drop_req_held", imem_req, 1'b1);
      check16("drop_addr_held", imem_addr, 16'h0010);
      lat = 1;
      addr_exp.push_back(16'h0040);
      push_out(16'h0040, 16'h0042);
      wait_valid_and_stall("after_drop");

      // Redirect on the same edge as the response
      lat = 2;
      addr_exp.push_back(16'h0042);
      stall = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      redirect = 1'b1; redirect_target = 16'h1235;
      @(posedge clk); #1;
      redirect = 1'b0;
      check1 ("same_edge_if_valid", if_valid, 1'b0);
      check16("same_edge_instruction", instruction, 16'h0000);
      check1 ("same_edge_imem_req", imem_req, 1'b0);
      lat = 1;
      addr_exp.push_back(16'h1234);
      push_out(16'h1234, 16'h1236);
      wait_valid_and_stall("after_same_edge");

      // Redirect kills a stalled instruction; fetch wraps at FFFE
      e = out_exp.pop_front();
      check16("killed_instr_visible", instruction, e.instr);
      redirect = 1'b1; redirect_target = 16'hFFFF;
      addr_exp.push_back(16'hFFFE);
      push_out(16'hFFFE, 16'h0000);
      @(posedge clk); #1;
      redirect = 1'b0;
      check1 ("kill_if_valid", if_valid, 1'b0);
      check16("kill_instruction", instruction, 16'h0000);
      stall = 1'b0;
      wait_valid_and_stall("wrap_fill");
      addr_exp.push_back(16'h0000);
      push_out(16'h0000, 16'h0002);
      stall = 1'b0;
      wait_valid_and_stall("wrap_next");

      // Reset during an outstanding request
      lat = 4;
      addr_exp.push_back(16'h0002);
      stall = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check1 ("midrst_imem_req", imem_req, 1'b0);
      check16("midrst_instruction", instruction, 16'h0000);
      check1 ("midrst_if_valid", if_valid, 1'b0);
      check16("midrst_pc_plus_2", pc_plus_2, 16'h0000);
      check16("midrst_imem_addr", imem_addr, 16'h0000);
      rst = 1'b0;
      lat = 1;
      addr_exp.push_back(16'h0000);
      push_out(16'h0000, 16'h0002);
      wait_valid_and_stall("after_rst");
      e = out_exp.pop_front();
      check16("restart_instruction", instruction, e.instr);
      check16("restart_pc_plus_2", pc_plus_2, e.pc2);

      @(posedge clk); #1;
      check_int("addr_queue_empty", addr_exp.size(), 0);
      check_int("out_queue_empty", out_exp.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_if_fetch_unit
`default_nettype wire
